// File: rtl/data_mem_responder.sv
// data_mem_responder: responder for the MEM-stage load/store interface.
// It models a word-addressed data memory with a fixed access latency and
// back-pressures the pipeline through ready (the core freezes on ~ready).
//
// Ports:
//   clk       in   clock; all state changes on the rising edge
//   rst       in   synchronous, active-high reset
//   MEM_r_en  in   load request
//   MEM_w_en  in   store request (wins if both enables are high)
//   address   in   [31:0] byte address from the ALU
//   wdata     in   [31:0] store data (Val_Rm)
//   rdata     out  [31:0] load result, registered; held until next read
//   ready     out  combinational; high when the MEM stage may advance
//   err       out  registered access-fault pulse during DONE
//
// Optional build macro DMEM_FAULT_CHECK_EN: when defined, accesses below
// BASE_ADDR, beyond DEPTH words, or not word-aligned are flagged on err,
// faulting stores are dropped and faulting loads return zero. When it is
// undefined, err stays low and addresses wrap modulo DEPTH.
module data_mem_responder #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 5,
  parameter int unsigned BASE_ADDR   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_r_en,
  input  logic        MEM_w_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = 8;
  localparam logic [31:0] BASE  = 32'(BASE_ADDR);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             wr_q, wr_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             mem_we;
  logic             access_fault;
  logic [IDX_W-1:0] idx;

  logic [31:0] mem_q [DEPTH];

  // Word index from the latched address; the truncation gives the wrap.
  assign idx = IDX_W'((addr_q - BASE) >> 2);

`ifdef DMEM_FAULT_CHECK_EN
  // Offset compared in full width so out-of-window addresses are caught.
  logic [31:0] word_off;
  assign word_off     = (addr_q - BASE) >> 2;
  assign access_fault = (addr_q < BASE) || (word_off >= 32'(DEPTH)) ||
                        (addr_q[1:0] != 2'b00);
`else
  assign access_fault = 1'b0;
`endif

  // Next-state and ready logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    ready   = 1'b0;
    case (state_q)
      IDLE: begin
        ready = ~(MEM_r_en | MEM_w_en);
        if (MEM_r_en | MEM_w_en) begin
          addr_d  = address;
          wdata_d = wdata;
          wr_d    = MEM_w_en;
          cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          // The access happens on the edge that enters DONE.
          state_d = DONE;
          err_d   = access_fault;
          if (wr_q) begin
            mem_we = ~access_fault;
          end else begin
            rdata_d = access_fault ? 32'h0 : mem_q[idx];
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        // The request still visible here is the completed one; ignore it.
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array storage; reset leaves contents alone but drops a pending store.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[idx] <= wdata_q;
    end
  end

  assign rdata = rdata_q;
  assign err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int unsigned WAITC = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_r_en;
  logic        MEM_w_en;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  int total = 0;
  int bad   = 0;

  data_mem_responder #(
    .DEPTH(64),
    .WAIT_CYCLES(WAITC),
    .BASE_ADDR(1024)
  ) dut (
    .clk(clk),
    .rst(rst),
    .MEM_r_en(MEM_r_en),
    .MEM_w_en(MEM_w_en),
    .address(address),
    .wdata(wdata),
    .rdata(rdata),
    .ready(ready),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request from IDLE and return at the DONE cycle with enables dropped.
  // With chg set, inputs are changed to a2/d2 in the first BUSY cycle.
  task automatic run_op(input string tag, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic chg, input logic [31:0] a2, input logic [31:0] d2,
                        input logic err_exp);
    int lat;
    @(negedge clk);
    MEM_r_en = r;
    MEM_w_en = w;
    address  = a;
    wdata    = d;
    #1;
    check({tag, " ready_on_req"}, 32'(ready), 32'd0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (chg && lat == 1) begin
        address = a2;
        wdata   = d2;
      end
    end while (!ready && lat < 50);
    check({tag, " latency"}, 32'(lat), 32'(WAITC + 1));
    check({tag, " err"}, 32'(err), 32'(err_exp));
    MEM_r_en = 1'b0;
    MEM_w_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    MEM_r_en = 1'b0;
    MEM_w_en = 1'b0;
    address  = 32'h0;
    wdata    = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state and combinational ready.
    check("rst rdata", rdata, 32'h0);
    check("rst err", 32'(err), 32'd0);
    check("rst ready_idle", 32'(ready), 32'd1);
    MEM_r_en = 1'b1;
    #1;
    check("rst ready_req", 32'(ready), 32'd0);
    MEM_r_en = 1'b0;

    // Preload word 2 so its prior value is known.
    run_op("pre1032", 1'b0, 1'b1, 32'd1032, 32'hAAAA5555, 1'b0, 32'h0, 32'h0, 1'b0);

    // Store then load.
    run_op("st1024", 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0, 1'b0);
    check("st1024 rdata_unchanged", rdata, 32'h0);
    run_op("ld1024", 1'b1, 1'b0, 32'd1024, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("ld1024 rdata_done", rdata, 32'hDEADBEEF);
    @(negedge clk);
    check("ld1024 rdata_idle", rdata, 32'hDEADBEEF);
    check("idle ready", 32'(ready), 32'd1);

    // Inputs changed while BUSY must be ignored.
    run_op("chg", 1'b0, 1'b1, 32'd1028, 32'h11, 1'b1, 32'd1032, 32'h22, 1'b0);
    run_op("chg ld1028", 1'b1, 1'b0, 32'd1028, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("chg word1", rdata, 32'h11);
    run_op("chg ld1032", 1'b1, 1'b0, 32'd1032, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("chg word2", rdata, 32'hAAAA5555);

    // Both enables: write wins, rdata untouched.
    run_op("both", 1'b1, 1'b1, 32'd1036, 32'h5, 1'b0, 32'h0, 32'h0, 1'b0);
    check("both rdata_held", rdata, 32'hAAAA5555);
    run_op("both ld", 1'b1, 1'b0, 32'd1036, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("both word3", rdata, 32'h5);

    // Reset in the third BUSY cycle of a store.
    run_op("pre1040", 1'b0, 1'b1, 32'd1040, 32'h77, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    MEM_w_en = 1'b1;
    address  = 32'd1040;
    wdata    = 32'h99;
    repeat (3) @(negedge clk);
    rst      = 1'b1;
    MEM_w_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("midrst rdata", rdata, 32'h0);
    check("midrst ready_idle", 32'(ready), 32'd1);
    MEM_r_en = 1'b1;
    #1;
    check("midrst ready_req", 32'(ready), 32'd0);
    MEM_r_en = 1'b0;
    run_op("midrst ld", 1'b1, 1'b0, 32'd1040, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("midrst word4", rdata, 32'h77);

`ifdef DMEM_FAULT_CHECK_EN
    // Out-of-range store faults and is dropped.
    run_op("oor st", 1'b0, 1'b1, 32'd1280, 32'h1234, 1'b0, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    check("oor err_cleared", 32'(err), 32'd0);
    run_op("oor ld0", 1'b1, 1'b0, 32'd1024, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("oor word0", rdata, 32'hDEADBEEF);
    run_op("unal ld", 1'b1, 1'b0, 32'd1025, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    check("unal rdata", rdata, 32'h0);
    run_op("low ld", 1'b1, 1'b0, 32'd1020, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    check("low rdata", rdata, 32'h0);
`else
    // Out-of-range address aliases word 0.
    run_op("alias st", 1'b0, 1'b1, 32'd1280, 32'h1234, 1'b0, 32'h0, 32'h0, 1'b0);
    run_op("alias ld0", 1'b1, 1'b0, 32'd1024, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("alias word0", rdata, 32'h1234);
    run_op("alias unal", 1'b1, 1'b0, 32'd1029, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("alias word1", rdata, 32'h11);
`endif

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
